// File: rtl/sseg_2hex_capture_pkg.sv
// sseg_pkg: shared definitions for seven-segment capture/checking logic.
//   SSEG_GLYPH  : 16 hex glyphs, gfedcba order, active-high (index = nibble)
//   SSEG_BLANK  : all-segments-off pattern on the active-low pins
//   sseg_state_e: capture FSM states
//   sseg_dec_t  : decoded pattern {legal, blank, nibble}
package sseg_pkg;

  localparam logic [6:0] SSEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } sseg_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } sseg_dec_t;

endpackage

// File: rtl/sseg_2hex_capture_if.sv
// sseg_2hex_capture_if: display pins plus recovered-digit outputs.
//   SEG[6:0]      : segment lines, active-low, bit0=a .. bit6=g
//   AN[1:0]       : digit anodes, active-low (AN[0] = digit 0)
//   HEX[7:0]      : recovered digits, HEX[3:0] = digit 0
//   DIG_VALID[1:0]: last capture per digit was a legal glyph
//   ERR[1:0]      : last capture per digit was neither glyph nor blank
//   UPDATE        : one-cycle pulse when any output field changes
// master = display driver / bench side, slave = capture block.
interface sseg_2hex_capture_if;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic [7:0] HEX;
  logic [1:0] DIG_VALID;
  logic [1:0] ERR;
  logic       UPDATE;

  modport master (output SEG, AN, input HEX, DIG_VALID, ERR, UPDATE);
  modport slave  (input SEG, AN, output HEX, DIG_VALID, ERR, UPDATE);
endinterface

// File: rtl/sseg_2hex_capture_decode.sv
// sseg_pattern_decode: combinational decode of one active-low segment pattern.
//   i_seg[6:0] : active-low segment lines (bit0=a .. bit6=g)
//   o_dec      : {legal, blank, nibble}; nibble is 0 unless legal
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] i_seg,
  output sseg_dec_t  o_dec
);

  logic [6:0] w_pat;
  sseg_dec_t  w_dec;

  always_comb begin
    w_dec = '0;
    w_pat = ~i_seg;
    // Glyphs are unique, so at most one entry matches.
    for (int i = 0; i < 16; i++) begin
      if (w_pat == SSEG_GLYPH[i]) begin
        w_dec.legal  = 1'b1;
        w_dec.nibble = 4'(i);
      end
    end
    w_dec.blank = (i_seg == SSEG_BLANK);
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/sseg_2hex_capture.sv
// sseg_2hex_capture: recovers two hex digits from a multiplexed 7-seg display.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of sseg_2hex_capture_if (SEG/AN in, HEX/DIG_VALID/ERR/UPDATE out)
// A digit is captured once SEG/AN have been identical for STABLE_CYCLES
// consecutive samples with exactly one anode active.
module sseg_2hex_capture
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  sseg_2hex_capture_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       r_seg;
  logic [1:0]       r_an;
  logic [CNT_W-1:0] r_cnt;
  sseg_state_e      r_state;

  logic [7:0] r_hex;
  logic [1:0] r_valid;
  logic [1:0] r_err;
  logic       r_update;

  sseg_state_e      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;
  logic             w_an_legal;
  logic             w_same;

  sseg_dec_t  w_dec;
  logic       w_dig;
  logic [3:0] w_nib_old;
  logic [3:0] w_nib_new;
  logic       w_val_new;
  logic       w_err_new;
  logic       w_changed;

  assign w_an_legal = (bus.AN == 2'b10) || (bus.AN == 2'b01);
  assign w_same     = (bus.SEG == r_seg) && (bus.AN == r_an);

  // Input sample stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SSEG_BLANK;
      r_an  <= 2'b11;
    end else begin
      r_seg <= bus.SEG;
      r_an  <= bus.AN;
    end
  end

  // FSM / stability counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decisions use the raw pins so the new sample, the count and
  // the state all line up after the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_an_legal) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (!w_same) begin
      w_state_nxt = TRACK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        TRACK: begin
          if (r_cnt == CNT_MAX - CNT_ONE) begin
            w_cnt_nxt   = CNT_MAX;
            w_state_nxt = LOCKED;
            w_capture   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        LOCKED: begin
          w_state_nxt = LOCKED;
        end
        default: begin
          // Stable legal anode while IDLE cannot follow from the sample
          // register; restart tracking if it ever does.
          w_state_nxt = TRACK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  sseg_pattern_decode u_decode (
    .i_seg (r_seg),
    .o_dec (w_dec)
  );

  // AN[1] low selects digit 1; only ever evaluated with a legal anode.
  assign w_dig     = (r_an == 2'b01);
  assign w_nib_old = w_dig ? r_hex[7:4] : r_hex[3:0];
  assign w_nib_new = w_dec.legal ? w_dec.nibble : w_nib_old;
  assign w_val_new = w_dec.legal;
  assign w_err_new = !w_dec.legal && !w_dec.blank;
  assign w_changed = (w_nib_new != w_nib_old) ||
                     (w_val_new != r_valid[w_dig]) ||
                     (w_err_new != r_err[w_dig]);

  // Output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex    <= 8'h00;
      r_valid  <= 2'b00;
      r_err    <= 2'b00;
      r_update <= 1'b0;
    end else begin
      r_update <= w_capture && w_changed;
      if (w_capture) begin
        if (w_dig) r_hex[7:4] <= w_nib_new;
        else       r_hex[3:0] <= w_nib_new;
        r_valid[w_dig] <= w_val_new;
        r_err[w_dig]   <= w_err_new;
      end
    end
  end

  assign bus.HEX       = r_hex;
  assign bus.DIG_VALID = r_valid;
  assign bus.ERR       = r_err;
  assign bus.UPDATE    = r_update;

endmodule

// File: tb/tb_sseg_2hex_capture.sv
// Directed bench for sseg_2hex_capture (STABLE_CYCLES = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sseg_2hex_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   upd_cnt = 0;
  int   upd_base;

  always #5 clk = ~clk;

  sseg_2hex_capture_if bus ();

  sseg_2hex_capture #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.UPDATE === 1'b1) upd_cnt <= upd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] an, input logic [6:0] seg);
    bus.AN  = an;
    bus.SEG = seg;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive(2'b11, 7'h7F);
    step(2);
    chk("rst_hex",   32'(bus.HEX),       32'h00);
    chk("rst_valid", 32'(bus.DIG_VALID), 32'h0);
    chk("rst_err",   32'(bus.ERR),       32'h0);
    chk("rst_upd",   32'(bus.UPDATE),    32'h0);
    rst = 1'b0;
    step(1);

    // 'A' on digit 0: visible only after the fourth stable edge
    upd_base = upd_cnt;
    drive(2'b10, 7'h08);
    step(4);
    chk("a_early_hex", 32'(bus.HEX), 32'h00);
    chk("a_early_upd", 32'(bus.UPDATE), 32'h0);
    step(1);
    chk("a_hex",   32'(bus.HEX),       32'h0A);
    chk("a_valid", 32'(bus.DIG_VALID), 32'h1);
    chk("a_upd",   32'(bus.UPDATE),    32'h1);
    step(1);
    chk("a_upd_low", 32'(bus.UPDATE), 32'h0);
    step(4);
    chk("a_upd_cnt", 32'(upd_cnt - upd_base), 32'd1);

    // Multiplexed '5' / '0', two full scans
    upd_base = upd_cnt;
    for (int r = 0; r < 2; r++) begin
      drive(2'b01, 7'h12);
      step(8);
      drive(2'b10, 7'h40);
      step(8);
    end
    chk("mux_hex",     32'(bus.HEX),       32'h50);
    chk("mux_valid",   32'(bus.DIG_VALID), 32'h3);
    chk("mux_upd_cnt", 32'(upd_cnt - upd_base), 32'd2);

    // Short '1' glitch followed by a held '8'
    upd_base = upd_cnt;
    drive(2'b10, 7'h79);
    step(3);
    chk("glitch_hex", 32'(bus.HEX), 32'h50);
    drive(2'b10, 7'h00);
    step(8);
    chk("eight_hex",     32'(bus.HEX), 32'h58);
    chk("eight_upd_cnt", 32'(upd_cnt - upd_base), 32'd1);

    // Illegal pattern on digit 1, then blank
    drive(2'b01, 7'h7E);
    step(8);
    chk("ill_err",   32'(bus.ERR),       32'h2);
    chk("ill_valid", 32'(bus.DIG_VALID), 32'h1);
    chk("ill_hex",   32'(bus.HEX),       32'h58);
    drive(2'b01, 7'h7F);
    step(8);
    chk("blank_err",   32'(bus.ERR),       32'h0);
    chk("blank_valid", 32'(bus.DIG_VALID), 32'h1);
    chk("blank_hex",   32'(bus.HEX),       32'h58);

    // Illegal anode combinations never capture
    upd_base = upd_cnt;
    drive(2'b00, 7'h12);
    step(10);
    drive(2'b11, 7'h40);
    step(6);
    chk("an_bad_hex",     32'(bus.HEX), 32'h58);
    chk("an_bad_upd_cnt", 32'(upd_cnt - upd_base), 32'd0);

    // Reset mid-count, then a full run after release
    drive(2'b10, 7'h0E);
    step(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_hex",   32'(bus.HEX),       32'h00);
    chk("mid_rst_valid", 32'(bus.DIG_VALID), 32'h0);
    chk("mid_rst_err",   32'(bus.ERR),       32'h0);
    step(2);
    rst = 1'b0;
    step(4);
    chk("f_early_hex", 32'(bus.HEX), 32'h00);
    step(1);
    chk("f_hex",   32'(bus.HEX),       32'h0F);
    chk("f_valid", 32'(bus.DIG_VALID), 32'h1);
    chk("f_upd",   32'(bus.UPDATE),    32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
